// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared phase encodings, opcode constants and NOP word for the sequencer and maincontrol
package cpu_pkg;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_WB     = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // True for the opcodes maincontrol actually decodes.
    function automatic logic is_known_opcode(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_IMM);
    endfunction

endpackage

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - combinational next-PC select (pc+4 or pc+offset) with word alignment
module pc_next_unit #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            taken,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] target;

    // Both sums wrap naturally at XLEN bits; the low two bits are cleared so
    // a misaligned offset still lands on a word boundary.
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        target   = taken ? (pc + branch_offset) : pc_plus4;
        pc_next  = {target[XLEN-1:2], 2'b00};
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer owning IR and PC (optional FETCH_SEQ_ILLEGAL_TRAP_EN)
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            ex_wait,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_offset,
    output logic [1:0]      state,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            illegal_op
);

    logic [1:0]      state_q;
    logic            req_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] pc_q;
    logic            taken_q;
    logic [XLEN-1:0] pc_next;
    logic            illegal_q;

    pc_next_unit #(.XLEN(XLEN)) u_pc_next (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .taken         (taken_q),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_next)
    );

    // Phase FSM plus IR, PC, fetch request and branch decision registers.
    // The request rises one cycle after FETCH is entered, so a response is
    // only accepted while req_q is already high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PH_FETCH;
            req_q     <= 1'b0;
            ir_q      <= NOP_INSN;
            pc_q      <= RESET_PC;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                PH_FETCH: begin
                    if (req_q && imem_ready) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= PH_DECODE;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                PH_DECODE: begin
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
                    if (!is_known_opcode(ir_q[6:0])) begin
                        illegal_q <= 1'b1;
                    end else begin
                        state_q   <= PH_EXEC;
                    end
`else
                    state_q <= PH_EXEC;
`endif
                end
                PH_EXEC: begin
                    if (!ex_wait) begin
                        taken_q <= branch & zero;
                        state_q <= PH_WB;
                    end
                end
                default: begin
                    pc_q    <= pc_next;
                    state_q <= PH_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    // Unknown opcodes simply flow through as NOPs in this build.
    assign illegal_op = 1'b0;
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

    assign state       = state_q;
    assign imem_req    = req_q;
    assign instruction = ir_q;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ex_wait;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic [1:0]  state;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        illegal_op;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_pc;
    logic [31:0] model_ir;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ex_wait       (ex_wait),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .state         (state),
        .instruction   (instruction),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from the first FETCH cycle (req low) back to the next FETCH.
    task automatic do_insn(input string tag, input logic [31:0] word, input int rwait,
                           input int xwait, input logic br, input logic zr,
                           input logic [31:0] off, input logic [31:0] exp_pc);
        imem_ready    = (rwait == 0);
        imem_rdata    = (rwait == 0) ? word : 32'hDEAD_BEEF;
        branch_offset = off;
        step();
        chk({tag, ".f_state"}, 32'(state), 32'd0);
        chk({tag, ".f_req"}, 32'(imem_req), 32'd1);
        chk({tag, ".f_addr"}, imem_addr, model_pc);
        for (int i = 0; i < rwait; i++) begin
            step();
            chk({tag, ".w_state"}, 32'(state), 32'd0);
            chk({tag, ".w_req"}, 32'(imem_req), 32'd1);
            chk({tag, ".w_ir"}, instruction, model_ir);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        ex_wait    = 1'b1;
        branch     = 1'b1;
        zero       = 1'b1;
        step();
        chk({tag, ".d_state"}, 32'(state), 32'd1);
        chk({tag, ".d_ir"}, instruction, word);
        chk({tag, ".d_req"}, 32'(imem_req), 32'd0);
        imem_rdata = 32'hBAD0_BAD0;
        step();
        chk({tag, ".x_state"}, 32'(state), 32'd2);
        for (int i = 0; i < xwait; i++) begin
            step();
            chk({tag, ".xs_state"}, 32'(state), 32'd2);
            chk({tag, ".xs_pc"}, pc, model_pc);
        end
        ex_wait = 1'b0;
        branch  = br;
        zero    = zr;
        step();
        chk({tag, ".wb_state"}, 32'(state), 32'd3);
        chk({tag, ".wb_ir"}, instruction, word);
        chk({tag, ".wb_pc"}, pc, model_pc);
        branch  = ~br;
        zero    = ~zr;
        step();
        chk({tag, ".n_state"}, 32'(state), 32'd0);
        chk({tag, ".n_pc"}, pc, exp_pc);
        chk({tag, ".n_pc4"}, pc_plus4, exp_pc + 32'd4);
        chk({tag, ".n_req"}, 32'(imem_req), 32'd0);
        chk({tag, ".n_ill"}, 32'(illegal_op), 32'd0);
        model_pc = exp_pc;
        model_ir = word;
        branch   = 1'b0;
        zero     = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h002081B3;
        ex_wait       = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        branch_offset = 32'h0;
        repeat (3) step();
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.pc", pc, 32'h0);
        chk("rst.ir", instruction, 32'h0000_0013);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.ill", 32'(illegal_op), 32'd0);

        // Straight-line add at 0x0 with zero-wait memory.
        rst_n = 1'b1;
        step();
        chk("sl.s0a", 32'(state), 32'd0);
        chk("sl.req", 32'(imem_req), 32'd1);
        step();
        chk("sl.s1", 32'(state), 32'd1);
        chk("sl.ir_d", instruction, 32'h002081B3);
        step();
        chk("sl.s2", 32'(state), 32'd2);
        chk("sl.ir_x", instruction, 32'h002081B3);
        step();
        chk("sl.s3", 32'(state), 32'd3);
        chk("sl.ir_w", instruction, 32'h002081B3);
        chk("sl.pc_w", pc, 32'h0);
        step();
        chk("sl.s0b", 32'(state), 32'd0);
        chk("sl.pc", pc, 32'h4);
        chk("sl.pc4", pc_plus4, 32'h8);
        model_pc = 32'h4;
        model_ir = 32'h002081B3;

        do_insn("fwait",   32'h0000_0013, 3, 0, 1'b0, 1'b0, 32'h0,        32'h8);
        do_insn("nop_c",   32'h0000_0013, 0, 0, 1'b0, 1'b1, 32'h0,        32'hC);
        do_insn("nop_10",  32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0,        32'h10);
        do_insn("beq_tk",  32'h0000_0063, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h08);
        do_insn("nop_c2",  32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0,        32'hC);
        do_insn("nop_102", 32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0,        32'h10);
        do_insn("beq_nt",  32'h0000_0063, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h14);
        do_insn("beq_bk",  32'h0000_0063, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10);
        do_insn("beq_al",  32'h0000_0063, 0, 5, 1'b1, 1'b1, 32'h0000_0006, 32'h14);
        do_insn("beq_hi",  32'h0000_0063, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFE8, 32'hFFFF_FFFC);
        do_insn("wrap",    32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0);

`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_007F;
        step();
        step();
        chk("ill.d_state", 32'(state), 32'd1);
        repeat (4) step();
        chk("ill.state", 32'(state), 32'd1);
        chk("ill.flag", 32'(illegal_op), 32'd1);
        chk("ill.req", 32'(imem_req), 32'd0);
        chk("ill.pc", pc, 32'h0);
        chk("ill.ir", instruction, 32'h0000_007F);
        rst_n = 1'b0;
        step();
        chk("ill.rst_flag", 32'(illegal_op), 32'd0);
        chk("ill.rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
`else
        do_insn("illegal", 32'h0000_007F, 0, 0, 1'b0, 1'b0, 32'h0, 32'h4);
`endif

        // Reset while the request is high and memory answers in the same cycle.
        imem_ready = 1'b0;
        step();
        chk("mrst.req_pre", 32'(imem_req), 32'd1);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        chk("mrst.state", 32'(state), 32'd0);
        chk("mrst.ir", instruction, 32'h0000_0013);
        chk("mrst.req", 32'(imem_req), 32'd0);
        chk("mrst.pc", pc, 32'h0);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
